// File: rtl/tawas_pkg.sv
// Shared definitions for the Tawas instruction ROM: loader state encoding,
// frame geometry and the default fill word.
package tawas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } ld_state_e;

  localparam int ADDR_BYTES = 3;
  localparam int WORD_BYTES = 4;

  // "BR +0": a core released onto unloaded memory spins in place.
  localparam logic [31:0] TAWAS_INIT_WORD = 32'hC000_8000;

endpackage

// File: rtl/tawas_irom_loader.sv
// Byte-stream loader for the Tawas instruction ROM: frame FSM, word assembly,
// write strobe, malformed-frame pulse and the core reset hold.
module tawas_irom_loader
  import tawas_pkg::*;
#(
  parameter int AW        = 10,
  parameter bit BOOT_HOLD = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          LD_VLD,
  output logic          LD_RDY,
  input  logic [7:0]    LD_DATA,
  input  logic          LD_LAST,
  output logic          LD_ERR,
  output logic          CORE_RST,
  output logic          WE,
  output logic [AW-1:0] WADDR,
  output logic [31:0]   WDATA
);

  ld_state_e     state_q, state_n;
  logic [1:0]    cnt_q, cnt_n;
  logic          ld_rdy_q, ld_err_q, core_rst_q;
  logic          good_q, good_n;
  logic          err_c, we_c, accept;
  logic [15:0]   addr_lo_q;
  logic [23:0]   word_q;
  logic [AW-1:0] wptr_q;
  logic [23:0]   full_addr;
  logic          unused_addr_bits;

  assign accept    = LD_VLD & ld_rdy_q;
  assign full_addr = {LD_DATA, addr_lo_q};
  assign unused_addr_bits = ^full_addr[23:AW];

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    good_n  = good_q;
    err_c   = 1'b0;
    we_c    = 1'b0;
    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (LD_LAST) begin
            err_c = 1'b1;
          end else begin
            state_n = ST_ADDR;
            cnt_n   = 2'd1;
          end
        end
        ST_ADDR: begin
          if (LD_LAST) begin
            err_c   = 1'b1;
            state_n = ST_IDLE;
            cnt_n   = 2'd0;
          end else if (cnt_q == 2'(ADDR_BYTES - 1)) begin
            state_n = ST_DATA;
            cnt_n   = 2'd0;
          end else begin
            cnt_n = cnt_q + 2'd1;
          end
        end
        ST_DATA: begin
          if (cnt_q == 2'(WORD_BYTES - 1)) begin
            we_c    = 1'b1;
            cnt_n   = 2'd0;
            state_n = LD_LAST ? ST_DONE : ST_DATA;
          end else if (LD_LAST) begin
            err_c   = 1'b1;
            state_n = ST_IDLE;
            cnt_n   = 2'd0;
          end else begin
            cnt_n = cnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
    if (state_q == ST_DONE) begin
      state_n = ST_IDLE;
      good_n  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      good_q     <= 1'b0;
      ld_rdy_q   <= 1'b0;
      ld_err_q   <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      good_q     <= good_n;
      ld_rdy_q   <= (state_n != ST_DONE);
      ld_err_q   <= err_c;
      // Held for the whole frame; in IDLE only the boot hold can keep it asserted.
      core_rst_q <= (state_n != ST_IDLE) || (BOOT_HOLD && !good_n);
    end
  end

  // Datapath registers carry no reset: they are only read once the FSM qualifies them.
  always_ff @(posedge CLK) begin
    if (accept) begin
      if (state_q == ST_IDLE) addr_lo_q[7:0] <= LD_DATA;
      if (state_q == ST_ADDR && cnt_q == 2'd1) addr_lo_q[15:8] <= LD_DATA;
      if (state_q == ST_ADDR && cnt_q == 2'(ADDR_BYTES - 1)) wptr_q <= full_addr[AW-1:0];
      if (state_q == ST_DATA) word_q <= {LD_DATA, word_q[23:8]};
    end
    if (we_c) wptr_q <= wptr_q + 1'b1;
  end

  assign LD_RDY   = ld_rdy_q;
  assign LD_ERR   = ld_err_q;
  assign CORE_RST = core_rst_q;
  assign WE       = we_c;
  assign WADDR    = wptr_q;
  assign WDATA    = {LD_DATA, word_q};

endmodule

// File: rtl/tawas_irom.sv
// Tawas instruction ROM: combinational fetch port over a loader-written array.
// Define TAWAS_IROM_PARITY_EN to store an even-parity bit per word and drive IPERR.
module tawas_irom
  import tawas_pkg::*;
#(
  parameter int          AW        = 10,
  parameter bit          BOOT_HOLD = 1'b1,
  parameter logic [31:0] INIT_WORD = TAWAS_INIT_WORD
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [23:0] IADDR,
  output logic [31:0] IDATA,
  input  logic        LD_VLD,
  output logic        LD_RDY,
  input  logic [7:0]  LD_DATA,
  input  logic        LD_LAST,
  output logic        LD_ERR,
  output logic        CORE_RST,
  output logic        IPERR
);

  localparam int DEPTH = 2 ** AW;

  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic [AW-1:0] raddr;
  logic          unused_iaddr;

  tawas_irom_loader #(
    .AW        (AW),
    .BOOT_HOLD (BOOT_HOLD)
  ) u_loader (
    .CLK      (CLK),
    .RST      (RST),
    .LD_VLD   (LD_VLD),
    .LD_RDY   (LD_RDY),
    .LD_DATA  (LD_DATA),
    .LD_LAST  (LD_LAST),
    .LD_ERR   (LD_ERR),
    .CORE_RST (CORE_RST),
    .WE       (we),
    .WADDR    (waddr),
    .WDATA    (wdata)
  );

  assign raddr        = IADDR[AW-1:0];
  assign unused_iaddr = ^IADDR[23:AW];

  // NOTE: the array has no reset; the declaration initialiser is a load-time fill, and RST never touches contents.
`ifdef TAWAS_IROM_PARITY_EN
  logic [32:0] mem_q [DEPTH] = '{default: {^INIT_WORD, INIT_WORD}};
  logic [32:0] rd_word;

  always_ff @(posedge CLK) begin
    if (we) mem_q[waddr] <= {^wdata, wdata};
  end

  assign rd_word = mem_q[raddr];
  assign IDATA   = rd_word[31:0];
  assign IPERR   = (^rd_word) & ~CORE_RST;
`else
  logic [31:0] mem_q [DEPTH] = '{default: INIT_WORD};

  always_ff @(posedge CLK) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign IDATA = mem_q[raddr];
  assign IPERR = 1'b0;
`endif

endmodule

// File: tb/tb_tawas_irom.sv
// Scoreboard bench for tawas_irom: stimulus queues expected port values,
// a negedge monitor pops and compares them and polices LD_ERR pulses.
module tb_tawas_irom;

  localparam logic [31:0] INIT = 32'hC000_8000;

  logic        CLK = 1'b0;
  logic        RST;
  logic [23:0] IADDR;
  logic [31:0] IDATA;
  logic        LD_VLD, LD_RDY, LD_LAST, LD_ERR, CORE_RST, IPERR;
  logic [7:0]  LD_DATA;

  int checks = 0;
  int errors = 0;

  typedef enum int {SIG_IDATA, SIG_CORE_RST, SIG_LD_RDY, SIG_IPERR} sig_e;
  typedef struct {
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];
  string err_q  [$];

  tawas_irom dut (
    .CLK      (CLK),
    .RST      (RST),
    .IADDR    (IADDR),
    .IDATA    (IDATA),
    .LD_VLD   (LD_VLD),
    .LD_RDY   (LD_RDY),
    .LD_DATA  (LD_DATA),
    .LD_LAST  (LD_LAST),
    .LD_ERR   (LD_ERR),
    .CORE_RST (CORE_RST),
    .IPERR    (IPERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // Monitor: compares every queued expectation against the live ports.
  always @(negedge CLK) begin
    exp_t        e;
    string       n;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      act = 32'h0;
      case (e.sig)
        SIG_IDATA:    act = IDATA;
        SIG_CORE_RST: act = {31'h0, CORE_RST};
        SIG_LD_RDY:   act = {31'h0, LD_RDY};
        SIG_IPERR:    act = {31'h0, IPERR};
        default:      act = 32'hxxxx_xxxx;
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", n, act, e.val);
      end
    end
    if (LD_ERR === 1'b1) begin
      checks++;
      if (err_q.size() > 0) begin
        n = err_q.pop_front();
      end else begin
        errors++;
        $display("FAIL unexpected_ld_err: got LD_ERR=1 expected 0 at %0t", $time);
      end
    end
  end

  function automatic void exp_sig(input sig_e s, input logic [31:0] v, input string n);
    exp_t e;
    e.sig = s;
    e.val = v;
    exp_q.push_back(e);
    name_q.push_back(n);
  endfunction

  // All tasks start and end at posedge+1.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    bit rdy;
    int n;
    n = 0;
    LD_VLD  = 1'b1;
    LD_DATA = d;
    LD_LAST = last;
    do begin
      @(negedge CLK);
      rdy = LD_RDY;
      @(posedge CLK);
      #1;
      n++;
    end while (!rdy && n < 100);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got LD_RDY=0 for %0d cycles expected 1", n);
    end
    LD_VLD  = 1'b0;
    LD_LAST = 1'b0;
  endtask

  task automatic send_addr(input logic [23:0] a);
    send_byte(a[7:0], 1'b0);
    send_byte(a[15:8], 1'b0);
    send_byte(a[23:16], 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    send_byte(w[7:0], 1'b0);
    send_byte(w[15:8], 1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[31:24], last);
  endtask

  task automatic read_check(input logic [23:0] a, input logic [31:0] v, input string n);
    IADDR = a;
    exp_sig(SIG_IDATA, v, n);
    exp_sig(SIG_IPERR, 32'h0, {n, "_iperr"});
    step();
  endtask

  logic [31:0] rwords [4];
  logic [23:0] rptr;

  initial begin
    RST = 1'b0; LD_VLD = 1'b0; LD_DATA = 8'h00; LD_LAST = 1'b0; IADDR = 24'h0;
    rwords[0] = 32'h1020_3040; rwords[1] = 32'h5060_7080;
    rwords[2] = 32'h90A0_B0C0; rwords[3] = 32'hD0E0_F001;

    // Reset state.
    step(3);
    exp_sig(SIG_LD_RDY,   32'h0, "rst_ld_rdy");
    exp_sig(SIG_CORE_RST, 32'h1, "rst_core_rst");
    exp_sig(SIG_IPERR,    32'h0, "rst_iperr");
    step();
    RST = 1'b1;
    step();
    exp_sig(SIG_LD_RDY,   32'h1, "idle_ld_rdy");
    exp_sig(SIG_CORE_RST, 32'h1, "boot_hold_idle");
    read_check(24'h000005, INIT, "fill_word");

    // Malformed frame before any good frame: first word kept, second dropped, boot hold stays.
    send_addr(24'h000020);
    send_word(32'h0BAD_F00D, 1'b0);
    send_byte(8'hEF, 1'b0);
    err_q.push_back("err_data_byte1");
    send_byte(8'hBE, 1'b1);
    exp_sig(SIG_CORE_RST, 32'h1, "boot_hold_after_err");
    exp_sig(SIG_LD_RDY,   32'h1, "err_back_to_idle");
    step(2);
    exp_sig(SIG_CORE_RST, 32'h1, "boot_hold_still");
    read_check(24'h000020, 32'h0BAD_F00D, "err_prior_word_kept");
    read_check(24'h000021, INIT, "err_partial_dropped");

    // Good frame at 0x10.
    send_byte(8'h10, 1'b0);
    exp_sig(SIG_CORE_RST, 32'h1, "core_rst_in_frame");
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(32'h1122_3344, 1'b0);
    send_word(32'h5566_7788, 1'b1);
    exp_sig(SIG_LD_RDY,   32'h0, "done_ld_rdy");
    exp_sig(SIG_CORE_RST, 32'h1, "done_core_rst");
    step();
    exp_sig(SIG_CORE_RST, 32'h0, "core_release");
    exp_sig(SIG_LD_RDY,   32'h1, "post_done_ld_rdy");
    read_check(24'h000010, 32'h1122_3344, "frame1_w0");
    read_check(24'h000011, 32'h5566_7788, "frame1_w1");
    read_check(24'hFFF011, 32'h5566_7788, "iaddr_high_ignored");

    // LD_LAST on an address byte after a good frame: CORE_RST asserts, then releases.
    send_byte(8'h00, 1'b0);
    exp_sig(SIG_CORE_RST, 32'h1, "core_assert_first_byte");
    err_q.push_back("err_addr_byte1");
    send_byte(8'h00, 1'b1);
    exp_sig(SIG_CORE_RST, 32'h0, "err_release");
    step();

    // Write pointer wrap at the top of the array.
    send_addr(24'h0003FF);
    send_word(32'hA5A5_0001, 1'b0);
    send_word(32'h5A5A_0002, 1'b1);
    step();
    read_check(24'h0003FF, 32'hA5A5_0001, "wrap_top");
    read_check(24'h000000, 32'h5A5A_0002, "wrap_zero");

    // Gapped stream, high address bits discarded (0x123040 -> 0x040), fetch tracking the write pointer.
    rptr = 24'h000040;
    send_addr(24'h123040);
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 3; b++) begin
        step(int'($urandom_range(0, 1)));
        send_byte(rwords[w][8*b +: 8], 1'b0);
      end
      step(int'($urandom_range(0, 1)));
      IADDR = rptr;
      exp_sig(SIG_IDATA, INIT, "same_cycle_old");
      send_byte(rwords[w][31:24], w == 3);
      exp_sig(SIG_IDATA, rwords[w], "next_cycle_new");
      rptr = rptr + 24'd1;
    end
    step();
    exp_sig(SIG_CORE_RST, 32'h0, "gapped_core_release");
    read_check(24'h000040, 32'h1020_3040, "gapped_w0_readback");

    // Reset in the middle of a data word, then a clean frame.
    send_addr(24'h000030);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hBA, 1'b0);
    RST = 1'b0;
    step();
    exp_sig(SIG_LD_RDY,   32'h0, "midrst_ld_rdy");
    exp_sig(SIG_CORE_RST, 32'h1, "midrst_core_rst");
    step();
    RST = 1'b1;
    step();
    exp_sig(SIG_LD_RDY,   32'h1, "postrst_ld_rdy");
    exp_sig(SIG_CORE_RST, 32'h1, "postrst_boot_hold");
    send_addr(24'h000030);
    send_word(32'h0102_0304, 1'b1);
    step();
    exp_sig(SIG_CORE_RST, 32'h0, "postrst_core_release");
    read_check(24'h000030, 32'h0102_0304, "postrst_frame");

`ifdef TAWAS_IROM_PARITY_EN
    dut.mem_q[10'h010] = dut.mem_q[10'h010] ^ 33'h0000_0008;
    IADDR = 24'h000010;
    exp_sig(SIG_IPERR, 32'h1, "parity_hit");
    step();
    IADDR = 24'h000011;
    exp_sig(SIG_IPERR, 32'h0, "parity_elsewhere");
    step();
`endif

    step(2);
    checks++;
    if (err_q.size() != 0) begin
      errors++;
      $display("FAIL missing_ld_err: got %0d pulses outstanding expected 0", err_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
